ro_puf_evaluator: RTL

- Read side of the 16-instance ring-oscillator PUF array.
- Accepts a challenge naming two oscillators and enables only that pair.
- Counts rising edges of each enabled oscillator over a fixed clock window, then compares the counts to produce one response bit.
- Sits between the RO array (drives the RO enables, samples the RO outputs) and the key/ID assembly logic (valid/ready response stream).

---
 rtl/ro_puf_pkg.sv | 19 +
 rtl/ro_edge_counter.sv | 34 +++
 rtl/ro_puf_evaluator.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared state encoding, default sizing and width helper for the RO PUF evaluator.
package ro_puf_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_COUNT, ST_RESP} state_t;

    localparam int DEF_N_RO   = 16;
    localparam int DEF_SEL_W  = 4;
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_WINDOW = 1024;
    localparam int DEF_SETTLE = 4;

    // One down-counter serves both phases, so it must hold the larger load value.
    function automatic int win_w(input int window, input int settle);
        return $clog2(((window > settle) ? window : settle) + 1);
    endfunction

    localparam int DEF_WIN_W = win_w(DEF_WINDOW, DEF_SETTLE);

endpackage

// File: rtl/ro_edge_counter.sv
// ro_edge_counter: 2-FF synchronizer, rising-edge detect and saturating edge counter for one RO.
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             cnt_en,
    input  logic             ro,
    output logic [CNT_W-1:0] cnt
);

    // sh[0], sh[1]: synchronizer stages; sh[2]: previous synchronized value.
    logic [2:0] sh;
    logic       rise;

    assign rise = sh[1] & ~sh[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh  <= '0;
            cnt <= '0;
        end else begin
            sh <= {sh[1:0], ro};
            if (clr)
                cnt <= '0;
            else if (cnt_en && rise && cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ro_puf_evaluator.sv
// ro_puf_evaluator: enables a challenged RO pair, counts their edges over a fixed window
// and returns a comparison bit on a valid/ready response stream.
module ro_puf_evaluator
    import ro_puf_pkg::*;
#(
    parameter int N_RO   = DEF_N_RO,
    parameter int SEL_W  = DEF_SEL_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int WINDOW = DEF_WINDOW,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] chal_a,
    input  logic [SEL_W-1:0] chal_b,
    output logic [N_RO-1:0]  ro_en,
    input  logic [N_RO-1:0]  ro_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_bit,
    output logic             rsp_tie,
    output logic             rsp_err,
    output logic [CNT_W-1:0] rsp_cnt_a,
    output logic [CNT_W-1:0] rsp_cnt_b
);

    localparam int TW = win_w(WINDOW, SETTLE);

    state_t           state;
    logic [SEL_W-1:0] idx_a;
    logic [SEL_W-1:0] idx_b;
    logic [TW-1:0]    tcnt;
    logic             err;
    logic             cap;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic [N_RO-1:0]  dec;
    logic             clr;
    logic             cnt_en;

    assign dec    = (N_RO'(1) << chal_a) | (N_RO'(1) << chal_b);
    assign clr    = (state == ST_IDLE) || (state == ST_SETTLE);
    assign cnt_en = (state == ST_COUNT);

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .cnt_en (cnt_en),
        .ro     (ro_in[idx_a]),
        .cnt    (cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .cnt_en (cnt_en),
        .ro     (ro_in[idx_b]),
        .cnt    (cnt_b)
    );

    // RESP spends its first cycle (cap) capturing the counters, which already include
    // the edge seen in the final COUNT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            ro_en     <= '0;
            idx_a     <= '0;
            idx_b     <= '0;
            tcnt      <= '0;
            err       <= 1'b0;
            cap       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_bit   <= 1'b0;
            rsp_tie   <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_cnt_a <= '0;
            rsp_cnt_b <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        idx_a     <= chal_a;
                        idx_b     <= chal_b;
                        req_ready <= 1'b0;
                        err       <= (chal_a == chal_b);
                        if (chal_a == chal_b) begin
                            state <= ST_RESP;
                            cap   <= 1'b1;
                        end else begin
                            state <= ST_SETTLE;
                            ro_en <= dec;
                            tcnt  <= TW'(SETTLE - 1);
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (tcnt == '0) begin
                        state <= ST_COUNT;
                        tcnt  <= TW'(WINDOW - 1);
                    end else begin
                        tcnt <= tcnt - 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (tcnt == '0) begin
                        state <= ST_RESP;
                        ro_en <= '0;
                        cap   <= 1'b1;
                    end else begin
                        tcnt <= tcnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (cap) begin
                        cap       <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_bit   <= !err && (cnt_a > cnt_b);
                        rsp_tie   <= !err && (cnt_a == cnt_b);
                        rsp_cnt_a <= cnt_a;
                        rsp_cnt_b <= cnt_b;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
